uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serialises 32-bit words from the DDR3 read FIFO onto the RS232 TX line, one 8N1 byte at a time. It mirrors `uart_receiver`: it sits between the user-side read FIFO and the board serial port, so frames buffered in DDR3 can be streamed back to the host. It runs on the FIFO read clock and pulls words only when the FIFO is non-empty.

## Interface
Parameters:
- `UART_BPS`, 460800: serial baud rate.
- `CLK_FREQ`, 25_000_000: frequency of `clk` in Hz.
- `FIFO_RD_WIDTH`, 32: width of the FIFO read data. Must equal 8 × `FIFO_RD_BYTE`.
- `FIFO_RD_BYTE`, 4: number of bytes sent per FIFO word.

Ports:
- `clk`, in, 1: single clock, same as the FIFO read clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `fifo_empty`, in, 1: read FIFO empty flag.
- `fifo_rd_data`, in, `FIFO_RD_WIDTH`: FIFO read data, valid one cycle after `fifo_rd_en`.
- `fifo_rd_en`, out, 1: FIFO read request, one-cycle pulse per word.
- `tx`, out, 1: RS232 serial output, idle high.
- `busy`, out, 1: high from the word fetch until the last stop bit of that word ends.

## Operation
- Bit period: `BAUD_CNT_MAX = CLK_FREQ / UART_BPS` (integer division, truncated). With the defaults this is 54 clocks. Every start, data and stop bit lasts exactly `BAUD_CNT_MAX` clocks.
- Frame format: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1). No parity.
- Byte order within a word: the most significant byte goes first. Byte k (k = 0 … `FIFO_RD_BYTE`-1) is `fifo_rd_data[W-1-8k : W-8-8k]`.
- State machine:
  - IDLE → RD_WAIT when `!fifo_empty`.
  - RD_WAIT → START unconditionally; the word is latched into the shift register at the end of this cycle.
  - START → DATA after one bit period.
  - DATA → STOP after 8 bit periods.
  - STOP → START after one bit period if the byte counter is below `FIFO_RD_BYTE`-1 (the counter increments on this transition).
  - STOP → IDLE after one bit period when the last byte is done.
- `fifo_rd_en = (state == IDLE) & !fifo_empty & !rst`. This is combinational, asserted for exactly one cycle per word, and never asserted outside IDLE.
- Counters:
  - Baud counter: 0 … `BAUD_CNT_MAX`-1, wraps on each bit end.
  - Bit counter: 0 … 7.
  - Byte counter: 0 … `FIFO_RD_BYTE`-1, width `$clog2(FIFO_RD_BYTE)` with a minimum of 1.
  - The baud counter clears on every state entry.
- Bytes within one word are sent back-to-back with no idle gap. Between words, the line stays high for the full stop bit plus the IDLE and RD_WAIT cycles.
- `tx` is registered and driven from the state and shift register only, so it is glitch-free.

## Timing
- Reset values: `tx` = 1, `busy` = 0, state = IDLE, all counters = 0. `fifo_rd_en` = 0 while `rst` is high.
- Latency:
  - Cycle N: `fifo_rd_en` high.
  - Cycle N+1: RD_WAIT; `busy` rises.
  - Cycle N+2: `tx` falls (start bit).
- Word duration: `tx` stays low/active for `10 × FIFO_RD_BYTE × BAUD_CNT_MAX` clocks starting at N+2. `busy` falls in the first IDLE cycle after the final stop bit.
- Back-to-back words (FIFO non-empty at the end of a word): the next `fifo_rd_en` fires in the first IDLE cycle. The next start bit begins 2 cycles later.
- `fifo_empty` is ignored outside IDLE. If the FIFO goes empty mid-word, the word still completes.
- Reset mid-operation: on the next clock edge `tx` = 1 and the state returns to IDLE. The partial word is discarded and is not re-read. A truncated frame on the line is acceptable.
- Reset coinciding with `!fifo_empty` in IDLE: no read is issued.

## Structure
- Shared package/header `uart_pkg` holds:
  - the state encoding (IDLE, RD_WAIT, START, DATA, STOP, 3-bit);
  - the `BAUD_CNT_MAX` computation, which is also reused by `uart_receiver`.
- One sub-module, `uart_baud_tick`: a baud counter with a clear input and a `bit_end` pulse output. `uart_transmitter` contains the FSM, the shift register and the bit and byte counters.

## Test plan
All scenarios use `CLK_FREQ` = 25_000_000 and `UART_BPS` = 460800 (54 clocks per bit) unless noted.
- **Reset:** hold `rst` = 1 for 5 cycles with `fifo_empty` = 0 → `tx` = 1, `busy` = 0, `fifo_rd_en` = 0 throughout.
- **Single word:** FIFO holds 0xA5C30F81 → exactly one `fifo_rd_en` pulse. The line carries bytes A5, C3, 0F, 81; the A5 data bits read 1,0,1,0,0,1,0,1. Each bit is 54 clocks, the word is 2160 clocks, and `busy` falls 2161 cycles after `busy` rises.
- **Back-to-back words:** FIFO holds 0x12345678 then 0xDEADBEEF → the second `fifo_rd_en` comes 1 cycle after the last stop bit of 0x78 ends, and the 0xDE start bit follows 2 cycles later. No third read occurs.
- **Reset mid-byte:** assert `rst` during bit 3 of byte C3 → `tx` = 1 on the next cycle and the FSM returns to IDLE. After release with the FIFO empty, no read occurs.
- **Byte-wide config:** `FIFO_RD_WIDTH` = 8, `FIFO_RD_BYTE` = 1, `CLK_FREQ` = 100, `UART_BPS` = 10 → word 0x3C is sent as a single 100-clock frame: start bit, then 0,0,1,1,1,1,0,0, then stop bit.
- **Empty mid-word:** `fifo_empty` rises during the second byte → all 4 bytes still complete, then the block stays in IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair.
//   uart_state_e : transmitter FSM state encoding (3-bit)
//   DataBits     : data bits per 8N1 frame
//   baud_cnt_max : clocks per bit period, truncated integer division
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdWait = 3'd1,
    StStart  = 3'd2,
    StData   = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam int unsigned DataBits = 8;

  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clear   : restart the period from zero (used on every state entry)
//   en      : count enable
//   bit_end : one-cycle pulse in the last clock of each CntMax-clock period
module uart_baud_tick #(
  parameter int unsigned CntMax = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic bit_end
);

  localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CntMax - 1);

  logic [CntW-1:0] cnt_q;

  assign bit_end = en && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// Streams FIFO words onto an RS232 line as 8N1 bytes, most significant byte first.
//   clk          : clock (FIFO read clock)
//   rst          : synchronous active-high reset
//   fifo_empty   : read FIFO empty flag, only looked at in idle
//   fifo_rd_data : read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   : one-cycle read request per word
//   tx           : registered serial output, idle high
//   busy         : high from the word fetch until the final stop bit ends
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned UART_BPS      = 460800,
  parameter int unsigned CLK_FREQ      = 25_000_000,
  parameter int unsigned FIFO_RD_WIDTH = 32,  // must be 8 * FIFO_RD_BYTE
  parameter int unsigned FIFO_RD_BYTE  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
  output logic                     fifo_rd_en,
  output logic                     tx,
  output logic                     busy
);

  localparam int unsigned BaudCntMax = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int unsigned ByteCntW   = (FIFO_RD_BYTE > 1) ? $clog2(FIFO_RD_BYTE) : 1;
  localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(FIFO_RD_BYTE - 1);
  localparam logic [2:0] LastBit = 3'(DataBits - 1);

  uart_state_e state_q, state_d;

  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [ByteCntW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [FIFO_RD_WIDTH-1:0] shift_q, shift_d;
  logic                     tx_q, tx_d;
  logic [7:0]               cur_byte;
  logic                     baud_en, baud_clr, bit_end;

  assign baud_en  = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  // Every state change restarts the bit period from zero.
  assign baud_clr = (state_d != state_q);

  uart_baud_tick #(
    .CntMax (BaudCntMax)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clr),
    .en      (baud_en),
    .bit_end (bit_end)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (!fifo_empty) state_d = StRdWait;
      StRdWait: state_d = StStart;
      StStart:  if (bit_end) state_d = StData;
      StData:   if (bit_end && (bit_cnt_q == LastBit)) state_d = StStop;
      StStop:   if (bit_end) state_d = (byte_cnt_q == LastByte) ? StIdle : StStart;
      default:  state_d = StIdle;
    endcase
  end

  // Counters and shift register next state.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    case (state_q)
      StRdWait: begin
        shift_d    = fifo_rd_data;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
      end
      // Wraps 7 -> 0 on the last data bit, ready for the next byte.
      StData: if (bit_end) bit_cnt_d = bit_cnt_q + 3'd1;
      StStop: begin
        if (bit_end) begin
          if (byte_cnt_q != LastByte) begin
            byte_cnt_d = byte_cnt_q + ByteCntW'(1);
            shift_d    = shift_q << 8;
          end else begin
            byte_cnt_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign cur_byte = shift_d[FIFO_RD_WIDTH-1 -: 8];

  // Outputs. tx is computed from the upcoming state so the registered line
  // lines up with state_q rather than lagging it by a cycle.
  always_comb begin
    fifo_rd_en = (state_q == StIdle) && !fifo_empty && !rst;
    busy       = (state_q != StIdle);
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte[bit_cnt_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int BitClk  = 54;
  localparam int ByteClk = 10 * BitClk;
  localparam int WordClk = 4 * ByteClk;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_en, tx, busy;

  logic        s_empty = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_rd_en, s_tx, s_busy;

  uart_transmitter #(
    .UART_BPS      (460800),
    .CLK_FREQ      (25_000_000),
    .FIFO_RD_WIDTH (32),
    .FIFO_RD_BYTE  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .tx           (tx),
    .busy         (busy)
  );

  uart_transmitter #(
    .UART_BPS      (10),
    .CLK_FREQ      (100),
    .FIFO_RD_WIDTH (8),
    .FIFO_RD_BYTE  (1)
  ) dut_s (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (s_empty),
    .fifo_rd_data (s_data),
    .fifo_rd_en   (s_rd_en),
    .tx           (s_tx),
    .busy         (s_busy)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] q[$];
  logic        stall = 1'b0;
  int          rd_cnt = 0;
  int          s_rd_cnt = 0;
  int          cyc = 0;
  bit          chk_on = 1'b0;

  // Reference model: time since the fetch cycle of the word in flight.
  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [31:0] m_word = '0;
  bit          exp_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Line level t cycles after the fetch: start at t=2, ten 54-clock bits per byte.
  function automatic logic model_tx(input bit act, input int t, input logic [31:0] w);
    int p, k, pos;
    if (!act || t < 2) return 1'b1;
    p   = t - 2;
    k   = p / ByteClk;
    pos = (p % ByteClk) / BitClk;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[24 - 8 * k + pos - 1];
  endfunction

  // Simple FIFOs feeding both instances.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && q.size() > 0) fifo_rd_data <= q.pop_front();
    if (s_rd_en) s_data <= 8'h3C;
  end

  always @(negedge clk) begin
    if (fifo_rd_en) rd_cnt++;
    if (s_rd_en) s_rd_cnt++;
  end

  // Compare process: check the big instance every cycle, then advance the model.
  always @(negedge clk) begin
    if (chk_on) begin
      exp_rd = !m_active && !fifo_empty && !rst;
      check("tx", 32'(tx), 32'(model_tx(m_active, m_t, m_word)));
      check("busy", 32'(busy), 32'(m_active));
      check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
      if (rst) begin
        m_active = 1'b0;
      end else if (exp_rd) begin
        m_active = 1'b1;
        m_t      = 1;
        m_word   = q[0];
      end else if (m_active) begin
        m_t++;
        if (m_t == WordClk + 2) m_active = 1'b0;
      end
    end
  end

  task automatic upd_empty();
    fifo_empty = (q.size() == 0) || stall;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    upd_empty();
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    upd_empty();
  endtask

  task automatic wait_rd(input int bound, output bit ok);
    int n = 0;
    #1;
    while (!fifo_rd_en && n < bound) begin
      step();
      n++;
    end
    ok = fifo_rd_en;
  endtask

  // Called in the fetch cycle; decodes the word from mid-bit samples of tx.
  task automatic capture(output logic [31:0] w, output int busy_len, output int frame_err);
    int c = 0;
    int b, k, pos;
    w = '0;
    busy_len = -1;
    frame_err = 0;
    while (busy_len < 0 && c < WordClk + 100) begin
      step();
      c++;
      if (c >= 2 && (c - 2) < WordClk && ((c - 2) % BitClk) == BitClk / 2) begin
        b   = (c - 2) / BitClk;
        k   = b / 10;
        pos = b % 10;
        if (pos == 0)      frame_err += (tx ? 1 : 0);
        else if (pos == 9) frame_err += (tx ? 0 : 1);
        else               w[24 - 8 * k + pos - 1] = tx;
      end
      if (!busy && c > 1) busy_len = c - 1;
    end
  endtask

  initial begin
    bit          ok;
    logic [31:0] w;
    int          bl, fe, r0, t1, t2, c, sbl;
    logic [9:0]  sf;

    rst = 1'b1;
    step();
    chk_on = 1'b1;

    // Reset held with a non-empty FIFO: no read, line idle.
    push(32'hA5C30F81);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    end
    check("rst_reads", rd_cnt, 32'd0);
    rst = 1'b0;

    // Single word.
    wait_rd(10, ok);
    check("single_rd_seen", 32'(ok), 32'd1);
    capture(w, bl, fe);
    check("single_word", w, 32'hA5C30F81);
    check("single_busy_len", bl, 32'd2161);
    check("single_framing", fe, 32'd0);
    repeat (20) step();
    check("single_reads", rd_cnt, 32'd1);

    // Back-to-back words.
    r0 = rd_cnt;
    push(32'h12345678);
    push(32'hDEADBEEF);
    wait_rd(10, ok);
    t1 = cyc;
    step();
    wait_rd(WordClk + 20, ok);
    t2 = cyc;
    check("b2b_rd_seen", 32'(ok), 32'd1);
    check("b2b_gap", t2 - t1, 32'd2162);
    capture(w, bl, fe);
    check("b2b_second_word", w, 32'hDEADBEEF);
    check("b2b_framing", fe, 32'd0);
    repeat (20) step();
    check("b2b_reads", rd_cnt - r0, 32'd2);

    // Reset in the middle of data bit 3 of byte C3 (that bit is 0).
    r0 = rd_cnt;
    push(32'hA5C30F81);
    wait_rd(10, ok);
    repeat (2 + ByteClk + 4 * BitClk + BitClk / 2) step();
    check("midrst_tx_before", 32'(tx), 32'd0);
    rst = 1'b1;
    step();
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (100) step();
    check("midrst_reads", rd_cnt - r0, 32'd1);
    check("midrst_idle", 32'(busy), 32'd0);

    // Byte-wide instance: 10 clocks per bit, single-byte words.
    s_empty = 1'b0;
    #1;
    c = 0;
    while (!s_rd_en && c < 20) begin
      step();
      c++;
    end
    check("byte_rd_seen", 32'(s_rd_en), 32'd1);
    step();
    s_empty = 1'b1;
    c   = 1;
    sf  = '0;
    sbl = -1;
    while (sbl < 0 && c < 200) begin
      step();
      c++;
      if (c >= 2 && (c - 2) < 100 && ((c - 2) % 10) == 5) sf[(c - 2) / 10] = s_tx;
      if (!s_busy) sbl = c - 1;
    end
    check("byte_frame", 32'(sf), 32'(10'b1001111000));
    check("byte_busy_len", sbl, 32'd101);
    check("byte_reads", s_rd_cnt, 32'd1);

    // Randomized traffic: sporadic pushes, flickering empty flag, rare resets.
    for (int i = 0; i < 22000; i++) begin
      step();
      if ($urandom_range(0, 15) == 0) stall = ~stall;
      if (q.size() < 2 && $urandom_range(0, 599) == 0) q.push_back($urandom);
      rst = ($urandom_range(0, 4999) == 0);
      upd_empty();
    end
    rst   = 1'b0;
    stall = 1'b0;
    upd_empty();
    c = 0;
    while ((q.size() > 0 || busy) && c < 10000) begin
      step();
      c++;
    end
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_queue", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
